// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package if_prefetch_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_INST_W     = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int unsigned PC_STEP        = 4;

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Show-ahead synchronous FIFO: the head entry is readable combinationally from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A pop frees the slot in the same edge, so push into a full queue is legal only with pop.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generator, single-outstanding ROM request and
// show-ahead prefetch queue with ID-side backpressure and branch redirect flush.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = DEF_ADDR_W,
    parameter int unsigned        INST_W     = DEF_INST_W,
    parameter int unsigned        FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              rom_ce_o,
    output logic [ADDR_W-1:0]                 rom_addr_o,
    input  logic [INST_W-1:0]                 rom_data_i,
    input  logic                              redirect_i,
    input  logic [ADDR_W-1:0]                 redirect_pc_i,
    input  logic                              id_ready_i,
    output logic                              id_valid_o,
    output logic [ADDR_W-1:0]                 id_pc_o,
    output logic [INST_W-1:0]                 id_inst_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       credit_used;
    logic [EW-1:0]     head;
    logic              fifo_empty;
    logic              unused_fifo_full;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Credit counts the in-flight fetch as occupied; id_ready_i never reaches rom_ce_o.
    assign credit_used = {1'b0, fifo_count_o} + (CW+1)'(inflight);
    assign issue       = ~rst & ~redirect_i & (credit_used < (CW+1)'(FIFO_DEPTH));
    assign rom_ce_o    = issue;
    assign rom_addr_o  = pc;

    assign push = inflight & ~redirect_i;
    assign pop  = id_valid_o & id_ready_i & ~redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect_i)
                pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            else if (issue)
                pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({inflight_pc, rom_data_i}),
        .dout  (head),
        .full  (unused_fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_o)
    );

    assign id_valid_o = ~fifo_empty;
    assign id_pc_o    = id_valid_o ? head[EW-1:INST_W] : '0;
    assign id_inst_o  = id_valid_o ? head[INST_W-1:0]  : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: cycle vectors for DEPTH=4 and DEPTH=2, an async reset
// sequence, and randomized traffic checked against an expected-PC-stream model.
module tb_if_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [2];
    logic        ready_v [2];
    logic        redir_v [2];
    logic [31:0] rpc_v   [2];
    logic [31:0] rom_v   [2];

    logic        ce4, ce2, val4, val2;
    logic [31:0] addr4, addr2, pc4, pc2, inst4, inst2;
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    if_prefetch #(.ADDR_W(32), .INST_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) u_d4 (
        .clk(clk), .rst(rst_v[0]), .rom_ce_o(ce4), .rom_addr_o(addr4), .rom_data_i(rom_v[0]),
        .redirect_i(redir_v[0]), .redirect_pc_i(rpc_v[0]), .id_ready_i(ready_v[0]),
        .id_valid_o(val4), .id_pc_o(pc4), .id_inst_o(inst4), .fifo_count_o(cnt4));

    if_prefetch #(.ADDR_W(32), .INST_W(32), .FIFO_DEPTH(2), .RESET_PC(32'h0)) u_d2 (
        .clk(clk), .rst(rst_v[1]), .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_data_i(rom_v[1]),
        .redirect_i(redir_v[1]), .redirect_pc_i(rpc_v[1]), .id_ready_i(ready_v[1]),
        .id_valid_o(val2), .id_pc_o(pc2), .id_inst_o(inst2), .fifo_count_o(cnt2));

    // ROM: word at address a is a | 0xA000; garbage when not read.
    always @(posedge clk) begin
        rom_v[0] <= ce4 ? (addr4 | 32'hA000) : $urandom;
        rom_v[1] <= ce2 ? (addr2 | 32'hA000) : $urandom;
    end

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  cnt;
    } obs_t;

    function automatic obs_t observe(input int d);
        obs_t o;
        if (d == 0) begin
            o.ce = ce4; o.addr = addr4; o.valid = val4; o.pc = pc4; o.inst = inst4; o.cnt = cnt4;
        end else begin
            o.ce = ce2; o.addr = addr2; o.valid = val2; o.pc = pc2; o.inst = inst2; o.cnt = {1'b0, cnt2};
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        bit          r, rdy, rd;
        logic [31:0] rpc;
        bit          ce;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        int          cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input int d, input bit r, input bit rdy, input bit rd,
                                input logic [31:0] rpc, input bit ce, input logic [31:0] addr,
                                input bit v, input logic [31:0] pc, input int cnt);
        vec_t t;
        t.d = d; t.r = r; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
        t.ce = ce; t.addr = addr; t.v = v; t.pc = pc; t.cnt = cnt;
        return t;
    endfunction

    task automatic add_rst(input int d);
        tv.push_back(mk(d, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    endtask

    task automatic fill_table();
        // DEPTH=4: streaming, one instruction per cycle
        add_rst(0);
        tv.push_back(mk(0,0,1,0,0, 1,32'h00,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0, 1,32'h04,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0, 1,32'h08,1,32'h0,1));
        tv.push_back(mk(0,0,1,0,0, 1,32'h0C,1,32'h4,1));
        tv.push_back(mk(0,0,1,0,0, 1,32'h10,1,32'h8,1));
        // DEPTH=4: stall for 10 cycles, then drain in order
        add_rst(0);
        tv.push_back(mk(0,0,0,0,0, 1,32'h00,0,32'h0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h04,0,32'h0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h08,1,32'h0,1));
        tv.push_back(mk(0,0,0,0,0, 1,32'h0C,1,32'h0,2));
        tv.push_back(mk(0,0,0,0,0, 0,32'h10,1,32'h0,3));
        for (int i = 0; i < 5; i++) tv.push_back(mk(0,0,0,0,0, 0,32'h10,1,32'h0,4));
        tv.push_back(mk(0,0,1,0,0, 0,32'h10,1,32'h00,4));
        tv.push_back(mk(0,0,1,0,0, 1,32'h10,1,32'h04,3));
        tv.push_back(mk(0,0,1,0,0, 1,32'h14,1,32'h08,2));
        tv.push_back(mk(0,0,1,0,0, 1,32'h18,1,32'h0C,2));
        tv.push_back(mk(0,0,1,0,0, 1,32'h1C,1,32'h10,2));
        // DEPTH=4: redirect at count=3/inflight=1, redirect+pop, double redirect, PC wrap
        add_rst(0);
        tv.push_back(mk(0,0,0,0,0, 1,32'h00,0,32'h0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h04,0,32'h0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h08,1,32'h0,1));
        tv.push_back(mk(0,0,0,0,0, 1,32'h0C,1,32'h0,2));
        tv.push_back(mk(0,0,0,1,32'h103,        0,32'h10,1,32'h0,3));
        tv.push_back(mk(0,0,1,0,0,              1,32'h100,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h104,0,32'h0,0));
        tv.push_back(mk(0,0,1,1,32'h200,        0,32'h108,1,32'h100,1));
        tv.push_back(mk(0,0,1,1,32'h300,        0,32'h200,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h300,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h304,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h308,1,32'h300,1));
        tv.push_back(mk(0,0,1,1,32'hFFFF_FFFF,  0,32'h30C,1,32'h304,1));
        tv.push_back(mk(0,0,1,0,0,              1,32'hFFFF_FFFC,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h0,0,32'h0,0));
        tv.push_back(mk(0,0,1,0,0,              1,32'h4,1,32'hFFFF_FFFC,1));
        tv.push_back(mk(0,0,1,0,0,              1,32'h8,1,32'h0,1));
        // DEPTH=2: streaming
        add_rst(1);
        tv.push_back(mk(1,0,1,0,0, 1,32'h00,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0, 1,32'h04,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0, 0,32'h08,1,32'h0,1));
        tv.push_back(mk(1,0,1,0,0, 1,32'h08,1,32'h4,1));
        tv.push_back(mk(1,0,1,0,0, 1,32'h0C,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0, 0,32'h10,1,32'h8,1));
        tv.push_back(mk(1,0,1,0,0, 1,32'h10,1,32'hC,1));
        tv.push_back(mk(1,0,1,0,0, 1,32'h14,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0, 0,32'h18,1,32'h10,1));
        // DEPTH=2: stall then drain
        add_rst(1);
        tv.push_back(mk(1,0,0,0,0, 1,32'h00,0,32'h0,0));
        tv.push_back(mk(1,0,0,0,0, 1,32'h04,0,32'h0,0));
        tv.push_back(mk(1,0,0,0,0, 0,32'h08,1,32'h0,1));
        tv.push_back(mk(1,0,0,0,0, 0,32'h08,1,32'h0,2));
        tv.push_back(mk(1,0,0,0,0, 0,32'h08,1,32'h0,2));
        tv.push_back(mk(1,0,1,0,0, 0,32'h08,1,32'h0,2));
        tv.push_back(mk(1,0,1,0,0, 1,32'h08,1,32'h4,1));
        tv.push_back(mk(1,0,1,0,0, 1,32'h0C,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0, 0,32'h10,1,32'h8,1));
        // DEPTH=2: redirect
        add_rst(1);
        tv.push_back(mk(1,0,1,0,0,       1,32'h00,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0,       1,32'h04,0,32'h0,0));
        tv.push_back(mk(1,0,1,1,32'h103, 0,32'h08,1,32'h0,1));
        tv.push_back(mk(1,0,1,0,0,       1,32'h100,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0,       1,32'h104,0,32'h0,0));
        tv.push_back(mk(1,0,1,0,0,       0,32'h108,1,32'h100,1));
    endtask

    task automatic run_table();
        obs_t o;
        foreach (tv[i]) begin
            rst_v[1 - tv[i].d] = 1'b1;
            rst_v[tv[i].d]     = tv[i].r;
            ready_v[tv[i].d]   = tv[i].rdy;
            redir_v[tv[i].d]   = tv[i].rd;
            rpc_v[tv[i].d]     = tv[i].rpc;
            #2;
            o = observe(tv[i].d);
            chk($sformatf("v%0d_ce",    i), o.ce,    tv[i].ce);
            chk($sformatf("v%0d_addr",  i), o.addr,  tv[i].addr);
            chk($sformatf("v%0d_valid", i), o.valid, tv[i].v);
            chk($sformatf("v%0d_pc",    i), o.pc,    tv[i].v ? tv[i].pc : 32'h0);
            chk($sformatf("v%0d_inst",  i), o.inst,  tv[i].v ? (tv[i].pc | 32'hA000) : 32'h0);
            chk($sformatf("v%0d_cnt",   i), o.cnt,   tv[i].cnt);
            @(negedge clk);
        end
    endtask

    // Async reset pulsed mid-cycle with two entries queued; stale ROM data must not be enqueued.
    task automatic rst_midstream();
        obs_t o;
        rst_v[0] = 1; rst_v[1] = 1; ready_v[0] = 0; redir_v[0] = 0; rpc_v[0] = '0;
        @(negedge clk);
        rst_v[0] = 0;
        repeat (3) @(negedge clk);
        #2;
        o = observe(0);
        chk("mid_cnt_before_rst", o.cnt, 3'd2);
        #1 rst_v[0] = 1;
        #1;
        o = observe(0);
        chk("mid_rst_ce", o.ce, 0);
        chk("mid_rst_addr", o.addr, 32'h0);
        chk("mid_rst_valid", o.valid, 0);
        chk("mid_rst_pc", o.pc, 32'h0);
        chk("mid_rst_inst", o.inst, 32'h0);
        chk("mid_rst_cnt", o.cnt, 3'd0);
        @(negedge clk);
        rst_v[0] = 0; ready_v[0] = 1;
        #2; o = observe(0);
        chk("post_rst_c0_addr", o.addr, 32'h0);
        chk("post_rst_c0_ce", o.ce, 1);
        @(negedge clk); #2; o = observe(0);
        chk("post_rst_c1_valid", o.valid, 0);
        chk("post_rst_c1_cnt", o.cnt, 3'd0);
        @(negedge clk); #2; o = observe(0);
        chk("post_rst_c2_valid", o.valid, 1);
        chk("post_rst_c2_pc", o.pc, 32'h0);
        chk("post_rst_c2_inst", o.inst, 32'hA000);
        @(negedge clk);
    endtask

    // Random traffic: delivered instructions must follow the expected PC stream.
    task automatic rand_run(input int d, input int n);
        obs_t        o;
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] prev_pc = 32'h0;
        bit          prev_hold = 0;
        bit          after_redir = 0;
        int          idle = 0;
        int          dep = (d == 0) ? 4 : 2;
        rst_v[0] = 1; rst_v[1] = 1; redir_v[d] = 0; ready_v[d] = 0;
        @(negedge clk);
        rst_v[d] = 0;
        for (int c = 0; c < n; c++) begin
            ready_v[d] = ($urandom_range(0, 99) < 70);
            redir_v[d] = ($urandom_range(0, 99) < 5);
            rpc_v[d]   = $urandom;
            #2;
            o = observe(d);
            if (after_redir) begin
                chk("rnd_flush_cnt", o.cnt, 3'd0);
                chk("rnd_flush_valid", o.valid, 0);
            end
            if (prev_hold) chk("rnd_head_stable", o.pc, prev_pc);
            chk("rnd_valid_vs_cnt", o.valid, o.cnt != 0);
            chk("rnd_cnt_bound", o.cnt <= 3'(dep), 1);
            if (!o.valid) begin
                chk("rnd_empty_pc", o.pc, 32'h0);
                chk("rnd_empty_inst", o.inst, 32'h0);
            end
            if (redir_v[d]) begin
                chk("rnd_redir_ce", o.ce, 0);
                exp_pc = rpc_v[d] & 32'hFFFF_FFFC;
                idle = 0;
            end else if (o.valid && ready_v[d]) begin
                chk("rnd_pc", o.pc, exp_pc);
                chk("rnd_inst", o.inst, exp_pc | 32'hA000);
                exp_pc = exp_pc + 32'd4;
                idle = 0;
            end else if (ready_v[d]) begin
                idle++;
            end
            if (idle > 8) begin
                chk("rnd_stall_bound", idle, 8);
                idle = 0;
            end
            after_redir = redir_v[d];
            prev_hold   = o.valid && !ready_v[d] && !redir_v[d];
            prev_pc     = o.pc;
            @(negedge clk);
        end
        redir_v[d] = 0;
        ready_v[d] = 1;
    endtask

    initial begin
        rst_v[0] = 1; rst_v[1] = 1;
        ready_v[0] = 0; ready_v[1] = 0;
        redir_v[0] = 0; redir_v[1] = 0;
        rpc_v[0] = '0; rpc_v[1] = '0;
        repeat (2) @(negedge clk);
        fill_table();
        run_table();
        rst_midstream();
        rand_run(0, 1500);
        rand_run(1, 1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
